// File: rtl/assertion_stim_gen_pkg.sv
// assertion_stim_gen_pkg: shared FSM state type, LFSR taps and no-error marker (package stim_pkg)
package stim_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;
    // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] NO_ERR    = 8'hFF;
endpackage

// File: rtl/assertion_stim_gen_if.sv
// assertion_stim_gen_if: stimulus/response bus to the checker under test (en, signal_in out; match, fail back)
interface assertion_stim_gen_if;
    logic en;
    logic signal_in;
    logic match;
    logic fail;
    modport master (output en, signal_in, input match, fail);
    modport slave  (input en, signal_in, output match, fail);
endinterface

// File: rtl/assertion_stim_gen_lfsr.sv
// stim_lfsr: 8-bit Fibonacci LFSR (ports clk, rst_n, load, step, seed, state); only built with STIM_GEN_LFSR_EN
`ifdef STIM_GEN_LFSR_EN
module stim_lfsr
    import stim_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] state
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= RST_VAL;
        else if (load)
            state <= seed;
        else if (step)
            state <= {state[6:0], ^(state & LFSR_TAPS)};
endmodule
`endif

// File: rtl/assertion_stim_gen.sv
// assertion_stim_gen: drives NUM_VEC vectors into a checker and scores its match/fail replies.
// Ports: clk, rst_n (async active-low), start, pattern[7:0], chk (master: en, signal_in out; match, fail in),
// busy, done, pass_cnt, err_cnt, first_err_idx. Macro STIM_GEN_LFSR_EN selects LFSR stimulus instead of pattern.
module assertion_stim_gen
    import stim_pkg::*;
#(
    parameter int         NUM_VEC   = 16,
    parameter int         CNT_W     = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           pattern,
    assertion_stim_gen_if.master chk,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [7:0]           first_err_idx
);
    state_t     state;
    logic [7:0] idx;
    logic       en_q, sig_q, cmp_valid, bit_next, exp_match, mismatch;
    wire        go = state == S_IDLE && start;

`ifdef STIM_GEN_LFSR_EN
    logic [7:0] lfsr_state;
    stim_lfsr #(.RST_VAL(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (go),
        .step  (state == S_DRIVE),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );
    assign bit_next = lfsr_state[0];
`else
    assign bit_next = pattern[idx[2:0]];
`endif

    // The checker answers the vector currently on the bus; its reply is scored at the next edge,
    // so cmp_valid trails the DRIVE state by one cycle and the final compare lands in DRAIN.
    assign exp_match     = sig_q & en_q;
    assign mismatch      = chk.match != exp_match || chk.fail != ~exp_match;
    assign chk.en        = en_q;
    assign chk.signal_in = sig_q;
    assign busy          = state == S_DRIVE || state == S_DRAIN;
    assign done          = state == S_DONE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            en_q          <= 1'b0;
            sig_q         <= 1'b0;
            cmp_valid     <= 1'b0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR;
        end else begin
            cmp_valid <= state == S_DRIVE;
            case (state)
                S_IDLE: if (start) begin
                    state         <= S_DRIVE;
                    idx           <= '0;
                    pass_cnt      <= '0;
                    err_cnt       <= '0;
                    first_err_idx <= NO_ERR;
                end
                S_DRIVE: begin
                    en_q  <= idx[1:0] != 2'b11;
                    sig_q <= bit_next;
                    idx   <= idx + 8'd1;
                    if (idx == 8'(NUM_VEC - 1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    en_q  <= 1'b0;
                    sig_q <= 1'b0;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
            if (cmp_valid) begin
                // idx has already moved one past the vector being scored
                if (mismatch) begin
                    err_cnt <= err_cnt + CNT_W'(err_cnt != '1);
                    if (first_err_idx == NO_ERR)
                        first_err_idx <= idx - 8'd1;
                end else
                    pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
            end
        end
endmodule

// File: doc/assertion_stim_gen.md
ASSERTION_STIM_GEN -- requirements
Module: assertion_stim_gen

Interface
REQ-001 Parameter NUM_VEC, default 16, number of vectors per run (2..255).
REQ-002 Parameter CNT_W, default 8, width of pass/error counters.
REQ-003 Parameter LFSR_SEED, default 8'hA5, nonzero LFSR start value.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle run request.
REQ-007 pattern  input  8  fixed stimulus pattern, used when LFSR is compiled out.
REQ-008 en  output  1  enable to checker under test.
REQ-009 signal_in  output  1  stimulus bit to checker under test.
REQ-010 match  input  1  checker match result.
REQ-011 fail  input  1  checker fail result.
REQ-012 busy  output  1  high from the first drive cycle through the last compare.
REQ-013 done  output  1  one-cycle pulse at run end.
REQ-014 pass_cnt  output  CNT_W  compared vectors that matched expectation.
REQ-015 err_cnt  output  CNT_W  compared vectors that mismatched expectation.
REQ-016 first_err_idx  output  8  index of first mismatching vector; 8'hFF if none.

Function
REQ-017 FSM states IDLE, DRIVE, DRAIN, DONE; IDLE->DRIVE on start; DRIVE->DRAIN after vector NUM_VEC-1; DRAIN->DONE after one cycle; DONE->IDLE after one cycle.
REQ-018 start sampled in IDLE clears pass_cnt, err_cnt, first_err_idx(=8'hFF), vector index idx=0.
REQ-019 In DRIVE, en and signal_in registered outputs, updated every cycle, one vector per cycle, idx incrementing 0..NUM_VEC-1.
REQ-020 en = 0 when idx[1:0]==2'b11, else 1 (exercises checker gating).
REQ-021 In IDLE, DRAIN, DONE: en=0, signal_in=0.
REQ-022 Expected model: match_exp(i) = signal_in(i) & en(i); fail_exp(i) = ~match_exp(i); compare of vector i on the cycle after vector i is driven (checker latency 1).
REQ-023 Compare valid exactly NUM_VEC cycles per run (last compare during DRAIN); mismatch if match!=match_exp or fail!=fail_exp.
REQ-024 Counters saturate at 2^CNT_W-1; first_err_idx written only on first mismatch of a run.
REQ-025 done pulses in DONE, i.e. NUM_VEC+2 cycles after the start edge; counts stable from done until next start.
REQ-026 start while not IDLE is ignored.
REQ-027 Checker outputs during a run do not alter FSM flow; only counters.

Reset
REQ-028 rst_n low asynchronously forces IDLE, en=0, signal_in=0, busy=0, done=0, pass_cnt=0, err_cnt=0, first_err_idx=8'hFF, idx=0, LFSR=LFSR_SEED.
REQ-029 Reset mid-run aborts with no done pulse; a new start is needed after release.

Configuration
REQ-030 Macro STIM_GEN_LFSR_EN defined: signal_in(i) = LFSR bit0, 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced once per DRIVE cycle, reloaded with LFSR_SEED on start.
REQ-031 Macro undefined: signal_in(i) = pattern[idx[2:0]]; no LFSR logic synthesized.

Structure
REQ-032 Package stim_pkg holds state enum, LFSR tap constant, 8'hFF no-error constant.
REQ-033 Sub-module stim_lfsr (load, step, seed, state out), instantiated only under STIM_GEN_LFSR_EN.

Verification
REQ-034 No LFSR, pattern=8'hFF, NUM_VEC=16, correct checker -> pass_cnt=16, err_cnt=0, first_err_idx=8'hFF, done 18 cycles after start.
REQ-035 No LFSR, pattern=8'h00, checker tied match=1 fail=0 -> err_cnt=16, pass_cnt=0, first_err_idx=0.
REQ-036 pattern=8'hFF, checker inverts match on vector 5 only -> err_cnt=1, pass_cnt=15, first_err_idx=5.
REQ-037 rst_n low at cycle 6 of a run -> all outputs at reset values immediately, no done; next start runs clean with full counts.
REQ-038 start pulsed repeatedly during DRIVE -> single run, one done pulse.
REQ-039 LFSR on, seed 8'hA5, correct checker -> signal_in sequence matches reference model, pass_cnt=16, err_cnt=0.
